// File: rtl/fb_pkg.sv
// fb_pkg: shared sizes and types for the framebuffer controller.
package fb_pkg;
    localparam int FB_SIZE_DEF = 76800;
    localparam int AW_DEF      = 32;

    typedef logic [7:0] pix_t;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} wr_state_t;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        pix_t              data;
    } wr_entry_t;
endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: 4-deep host write buffer, used only when FB_WRFIFO_EN is defined.
// Latency: an entry pushed at an edge is visible on dout from that edge onward.
// Backpressure: full blocks pushes; pop on empty is ignored.
module fb_wr_fifo #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [4];
    logic [1:0]   wp;
    logic [1:0]   rp;
    logic [2:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt == 3'd4);
    assign empty   = (cnt == 3'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= 2'd0;
            rp  <= 2'd0;
            cnt <= 3'd0;
        end else begin
            if (do_push) wp <= wp + 2'd1;
            if (do_pop)  rp <= rp + 2'd1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/fb_ctrl.sv
// fb_ctrl: framebuffer sequencer - LCD scan reads, host writes, full-frame clear (FB_WRFIFO_EN adds a write FIFO).
// Latency: pix_valid 1 cycle after pix_req; host write reaches fb_wre 1 cycle after handshake (2 with FIFO).
// Backpressure: host_wready low during clear, or while the write FIFO is full when FB_WRFIFO_EN is defined.
module fb_ctrl
    import fb_pkg::*;
#(
    parameter int FB_SIZE = FB_SIZE_DEF,
    parameter int AW      = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scan_start,
    input  logic          pix_req,
    output logic [7:0]    pix_data,
    output logic          pix_valid,
    output logic          frame_done,
    input  logic          host_wvalid,
    output logic          host_wready,
    input  logic [AW-1:0] host_waddr,
    input  logic [7:0]    host_wdata,
    output logic          host_werr,
    input  logic          clr_start,
    input  logic [7:0]    clr_color,
    output logic          clr_busy,
    output logic [AW-1:0] fb_wad,
    output logic [7:0]    fb_din,
    output logic          fb_wre,
    output logic [AW-1:0] fb_rad,
    input  logic [7:0]    fb_dout
);
    localparam logic [AW-1:0] LAST = AW'(FB_SIZE - 1);

    wr_state_t     state;
    logic [AW-1:0] scan_cnt;
    logic [AW-1:0] clr_cnt;
    pix_t          clr_val;
    logic          run;
    logic          wr_vld;
    logic [AW-1:0] wr_addr;
    pix_t          wr_data;

    assign fb_rad   = scan_start ? '0 : scan_cnt;
    assign pix_data = pix_valid ? fb_dout : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt   <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pix_valid  <= pix_req;
            frame_done <= pix_req && (fb_rad == LAST);
            if (pix_req)
                scan_cnt <= (fb_rad == LAST) ? '0 : fb_rad + AW'(1);
            else if (scan_start)
                scan_cnt <= '0;
        end
    end

`ifdef FB_WRFIFO_EN
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW+7:0] fifo_q;

    assign host_wready        = run && !fifo_full;
    // Buffered writes only drain while idle, so anything queued during a clear lands on top of it.
    assign wr_vld             = !fifo_empty && (state == IDLE);
    assign {wr_addr, wr_data} = fifo_q;

    fb_wr_fifo #(.W(AW + 8)) u_wr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (host_wvalid && host_wready),
        .din   ({host_waddr, host_wdata}),
        .pop   (wr_vld),
        .dout  (fifo_q),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
`else
    assign host_wready = run && (state == IDLE);
    assign wr_vld      = host_wvalid && host_wready;
    assign wr_addr     = host_waddr;
    assign wr_data     = host_wdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run       <= 1'b0;
            clr_cnt   <= '0;
            clr_val   <= '0;
            clr_busy  <= 1'b0;
            fb_wre    <= 1'b0;
            fb_wad    <= '0;
            fb_din    <= '0;
            host_werr <= 1'b0;
        end else begin
            run       <= 1'b1;
            fb_wre    <= 1'b0;
            host_werr <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_vld) begin
                        if (wr_addr <= LAST) begin
                            fb_wre <= 1'b1;
                            fb_wad <= wr_addr;
                            fb_din <= wr_data;
                        end else begin
                            host_werr <= 1'b1;
                        end
                    end
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_val  <= clr_color;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    fb_wre <= 1'b1;
                    fb_wad <= clr_cnt;
                    fb_din <= clr_val;
                    if (clr_cnt == LAST) begin
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_ctrl.sv
// tb_fb_ctrl: randomized scan/write/clear stimulus with a scoreboard against a frame-level memory model.
module tb_fb_ctrl;
    localparam int N  = 300;
    localparam int AW = 32;
    localparam int K  = 100;
`ifdef FB_WRFIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_start = 1'b0, pix_req = 1'b0;
    logic [7:0]    pix_data;
    logic          pix_valid, frame_done;
    logic          host_wvalid = 1'b0, host_wready;
    logic [AW-1:0] host_waddr = '0;
    logic [7:0]    host_wdata = '0;
    logic          host_werr;
    logic          clr_start = 1'b0;
    logic [7:0]    clr_color = '0;
    logic          clr_busy;
    logic [AW-1:0] fb_wad, fb_rad;
    logic [7:0]    fb_din, fb_dout;
    logic          fb_wre;

    fb_ctrl #(.FB_SIZE(N), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .scan_start(scan_start), .pix_req(pix_req),
        .pix_data(pix_data), .pix_valid(pix_valid), .frame_done(frame_done),
        .host_wvalid(host_wvalid), .host_wready(host_wready), .host_waddr(host_waddr),
        .host_wdata(host_wdata), .host_werr(host_werr), .clr_start(clr_start),
        .clr_color(clr_color), .clr_busy(clr_busy), .fb_wad(fb_wad), .fb_din(fb_din),
        .fb_wre(fb_wre), .fb_rad(fb_rad), .fb_dout(fb_dout)
    );

    always #5 clk = ~clk;

    // Dual-port RAM the controller drives; read-during-write returns the old word.
    logic [7:0] ram [N];
    logic       preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < N; i++) ram[i] <= 8'(i);
        end else if (fb_wre && fb_wad < 32'(N)) begin
            ram[fb_wad[8:0]] <= fb_din;
        end
        fb_dout <= (fb_rad < 32'(N)) ? ram[fb_rad[8:0]] : 8'h00;
    end

    typedef struct { logic [7:0] d; logic last; } exp_t;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] ref_mem [N];
    int         ptr = 0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pix_valid) begin
            if (sb.size() == 0) begin
                chk("pix_unexpected", 32'(pix_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("pix_data", 32'(pix_data), 32'(mon_e.d));
                chk("frame_done", 32'(frame_done), 32'(mon_e.last));
            end
        end else if (frame_done) begin
            chk("frame_done_stray", 32'(frame_done), 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n reads; optional scan_start on the first cycle; optional random idle gaps.
    task automatic scan(input int n, input bit with_start, input bit gaps);
        int done = 0;
        bit first = 1'b1;
        int g = 0;
        while (done < n) begin
            pix_req    = !gaps || ($urandom_range(0, 3) != 0);
            scan_start = first && with_start;
            first      = 1'b0;
            if (scan_start) ptr = 0;
            if (pix_req) begin
                sb.push_back('{ref_mem[ptr], ptr == N - 1});
                ptr = (ptr + 1) % N;
                done++;
            end
            step(1);
        end
        pix_req    = 1'b0;
        scan_start = 1'b0;
        while (sb.size() != 0 && g < 8) begin step(1); g++; end
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        int g = 0;
        while (!host_wready && g < 2 * N) begin step(1); g++; end
        chk("wready_wait", 32'(host_wready), 32'd1);
        host_wvalid = 1'b1;
        host_waddr  = a;
        host_wdata  = d;
        step(1);
        host_wvalid = 1'b0;
        if (LAT > 1) step(LAT - 1);
        chk("wr_wre", 32'(fb_wre), 32'(a < 32'(N)));
        chk("wr_werr", 32'(host_werr), 32'(a >= 32'(N)));
        if (a < 32'(N)) begin
            chk("wr_wad", fb_wad, a);
            chk("wr_din", 32'(fb_din), 32'(d));
            ref_mem[a[8:0]] = d;
        end
    endtask

    task automatic do_clear(input logic [7:0] c, input bit second, input bit with_write);
        int busy_n = 0;
        int rdy_bad = 0;
        int g = 0;
        clr_start = 1'b1;
        clr_color = c;
        if (with_write) begin
            host_wvalid = 1'b1;
            host_waddr  = 32'd10;
            host_wdata  = 8'h11;
        end
        step(1);
        clr_start   = 1'b0;
        host_wvalid = 1'b0;
        if (with_write && LAT == 1) begin
            chk("simul_wre", 32'(fb_wre), 32'd1);
            chk("simul_wad", fb_wad, 32'd10);
        end
        while (clr_busy && g < N + 100) begin
            busy_n++;
            if (host_wready) rdy_bad++;
            clr_start = second && (busy_n == N / 2);
            clr_color = ~c;
            step(1);
            g++;
        end
        clr_start = 1'b0;
        chk("clr_busy_len", 32'(busy_n), 32'(N));
        chk("wready_in_clear", 32'(rdy_bad), 32'd0);
        chk("wready_after_clear", 32'(host_wready), 32'd1);
        for (int i = 0; i < N; i++) ref_mem[i] = c;
`ifdef FB_WRFIFO_EN
        if (with_write) ref_mem[10] = 8'h11;
`endif
        step(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int acc;
        int g;
        preload = 1'b1;
        for (int i = 0; i < N; i++) ref_mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_werr", 32'(host_werr), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_fb_wre", 32'(fb_wre), 32'd0);
        chk("rst_fb_wad", fb_wad, 32'd0);
        chk("rst_fb_din", 32'(fb_din), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_wready", 32'(host_wready), 32'd0);
        chk("rst_fb_rad", fb_rad, 32'd0);
        preload = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);

        // full frame plus wrap into the next one
        scan(N + 2, 1'b1, 1'b0);

        host_write(32'd5, 8'hA5);
        host_write(32'(N), 8'h77);
        step(2);
        scan(N, 1'b1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 6) == 0) ? 32'(N + $urandom_range(0, 50))
                                            : 32'($urandom_range(0, N - 1));
            host_write(a, 8'($urandom));
        end
        step(2);
        scan(N + $urandom_range(0, 20), 1'b1, 1'b1);

        do_clear(8'h3C, 1'b1, 1'b0);
        scan(N, 1'b1, 1'b1);

        do_clear(8'h00, 1'b0, 1'b1);
        step(6);
        scan(N, 1'b1, 1'b0);

        // reset while the clear engine is part-way through the frame
        for (int i = 0; i < 20; i++) host_write(32'(K + i), 8'($urandom));
        step(2);
        clr_start = 1'b1;
        clr_color = 8'h5A;
        step(1);
        clr_start = 1'b0;
        g = 0;
        while (!(fb_wre && fb_wad == 32'(K)) && g < N + 10) begin step(1); g++; end
        chk("reach_clear_addr", fb_wad, 32'(K));
        rst_n = 1'b0;
        #1;
        chk("arst_fb_wre", 32'(fb_wre), 32'd0);
        chk("arst_fb_wad", fb_wad, 32'd0);
        chk("arst_fb_din", 32'(fb_din), 32'd0);
        chk("arst_clr_busy", 32'(clr_busy), 32'd0);
        chk("arst_wready", 32'(host_wready), 32'd0);
        chk("arst_werr", 32'(host_werr), 32'd0);
        for (int i = 0; i < K; i++) ref_mem[i] = 8'h5A;
        ptr = 0;
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("post_rst_wready", 32'(host_wready), 32'd1);
        chk("post_rst_clr_busy", 32'(clr_busy), 32'd0);
        scan(N, 1'b0, 1'b1);

`ifdef FB_WRFIFO_EN
        clr_start = 1'b1;
        clr_color = 8'hC3;
        step(1);
        clr_start   = 1'b0;
        acc         = 0;
        host_wvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            host_waddr = 32'(20 + acc);
            host_wdata = 8'(40 + acc);
            if (host_wready) acc++;
            step(1);
        end
        host_wvalid = 1'b0;
        chk("fifo_accepted", 32'(acc), 32'd4);
        chk("fifo_full_wready", 32'(host_wready), 32'd0);
        g = 0;
        while (clr_busy && g < N + 10) begin step(1); g++; end
        chk("fifo_clear_done", 32'(clr_busy), 32'd0);
        for (int i = 0; i < N; i++) ref_mem[i] = 8'hC3;
        for (int i = 0; i < 4; i++) ref_mem[20 + i] = 8'(40 + i);
        step(8);
        scan(N, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fb_ctrl.md
Name: fb_ctrl

Overview:
Framebuffer controller that sequences the single-clock, dual-port 8-bit framebuffer RAM (one write port, one read port, 1-cycle registered read). It drives the read port from an LCD scan-out address counter. It arbitrates the write port between a host pixel-write interface and a built-in frame-clear engine. It sits between the LCD timing generator, the host/command logic and the framebuffer RAM.

Parameters:
FB_SIZE, 76800, framebuffer depth in pixels (320x240); addresses 0..FB_SIZE-1
AW, 32, address width presented to the framebuffer RAM ports

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
scan_start  in  1  frame-start pulse from LCD timing; rewinds scan address
pix_req  in  1  LCD timing requests next pixel this cycle
pix_data  out  8  pixel read from framebuffer
pix_valid  out  1  pix_data valid; exactly 1 cycle after pix_req
frame_done  out  1  1-cycle pulse coincident with pix_valid of pixel FB_SIZE-1
host_wvalid  in  1  host write request
host_wready  out  1  host write accepted when wvalid&&wready
host_waddr  in  AW  host pixel address
host_wdata  in  8  host pixel value
host_werr  out  1  1-cycle pulse: accepted write had address >= FB_SIZE
clr_start  in  1  start full-frame clear
clr_color  in  8  fill value, sampled on accepted clr_start
clr_busy  out  1  clear engine active
fb_wad  out  AW  framebuffer write address
fb_din  out  8  framebuffer write data
fb_wre  out  1  framebuffer write enable
fb_rad  out  AW  framebuffer read address
fb_dout  in  8  framebuffer read data (1-cycle latency)

Behaviour:
- Reset (async, rst_n=0): scan counter=0, state=IDLE. pix_valid, frame_done, host_werr, clr_busy, fb_wre all 0. fb_wad, fb_din, pix_data 0. host_wready 0 while in reset.
- Read path: fb_rad combinational = scan_start ? 0 : scan_cnt. On pix_req: scan_cnt <= (fb_rad==FB_SIZE-1) ? 0 : fb_rad+1. On scan_start without pix_req: scan_cnt <= 0. pix_valid <= pix_req (registered). pix_data = fb_dout. frame_done <= pix_req && fb_rad==FB_SIZE-1.
- scan_start with pix_req in the same cycle: that request reads address 0; scan_cnt becomes 1.
- Write path FSM, states IDLE and CLEAR:
  - IDLE: host_wready=1. An accepted write with addr<FB_SIZE registers fb_wre=1, fb_wad, fb_din; the RAM is written the following cycle. An accepted write with addr>=FB_SIZE is dropped: fb_wre=0, host_werr=1 the next cycle.
  - IDLE + clr_start: the clear is accepted. Capture clr_color. Go to CLEAR with clr_busy=1 the next cycle. A host write handshaked in the same cycle is still issued, then overwritten by the clear.
  - CLEAR: host_wready=0. fb_wre=1 for FB_SIZE consecutive cycles, fb_wad=0..FB_SIZE-1, fb_din=captured color. After the address FB_SIZE-1 write is issued, return to IDLE. clr_busy falls in the same cycle that host_wready rises. clr_start during CLEAR is ignored.
- Scan reads continue during CLEAR. A read and a write to the same address in the same cycle returns the old data; this is not a hazard to fix.
- Reset mid-clear aborts the clear; the RAM is left partially filled.

Optional Feature:
FB_WRFIFO_EN
- Defined: a 4-entry host write FIFO (addr+data) is added. host_wready = !fifo_full in both states. The FIFO drains one entry per cycle in IDLE only. Entries accepted during CLEAR are written after the clear, so they survive. host_werr pulses when an out-of-range entry is popped.
- Undefined: no buffering, behaviour exactly as above.

Decomposition:
- Package fb_pkg: FB_SIZE/AW defaults, pixel type (8-bit), write-FSM state enum {IDLE, CLEAR}, host write entry struct {addr, data}.
- One sub-module: fb_wr_fifo (4-deep synchronous FIFO, rst_n async), instantiated only under FB_WRFIFO_EN.

Test Plan:
- Scan: preload RAM with ram[i]=i[7:0]; scan_start then pix_req held FB_SIZE+2 cycles -> pix_data 0x00,0x01,... 1 cycle after each req; frame_done exactly at pixel 76799 (0xFF); the next two reads return 0x00,0x01 (wrap).
- Host write: write addr 5 data 0xA5, then scan to 5 -> pix_data 0xA5. Write addr 76800 -> host_werr pulse 1 cycle later, fb_wre stays 0.
- Clear: clr_start with clr_color=0x3C -> clr_busy high for 76800 cycles, host_wready low throughout; full scan returns all 0x3C; a second clr_start mid-clear is ignored (busy length unchanged).
- Simultaneous: host write (addr 10, 0x11) in the same cycle as clr_start(0x00) -> ram[10]=0x00 after clear. scan_start+pix_req in the same cycle -> address 0 returned, next request returns address 1.
- Reset mid-clear: drop rst_n at clear address 1000 -> all outputs 0 immediately; after release, host_wready=1, clr_busy=0, ram[0..999]=color, ram[1000+] unchanged.
- FB_WRFIFO_EN: during CLEAR push 4 writes -> host_wready drops after 4; after clr_busy falls, all 4 land in order and read back correctly.
